sprite_dbuf: RTL and testbench
==============================

// Module: sprite_dbuf
// PURPOSE
// - Double-buffered 128x128 RGB666 sprite store that feeds the LCD pixel pipeline; replaces static image ROM.
// - MCU loads the back bank over the SPI bus; display reads the front bank; banks swap only at frame start (tear-free).
// - Includes a hardware fill engine that clears the back bank to a colour.
// PARAMETERS
// - IDX_W     14            pixel index width ({row[6:0], col[6:0]}), depth = 2**IDX_W per bank
// - PIX_W     18            pixel width, RGB666 {r[17:12], g[11:6], b[5:0]}
// PORTS
// - clk_50mhz    in   1      system clock; all logic in this domain
// - rst          in   1      synchronous, active-high reset
// - bus_addr     in   32     SPI-slave bus address
// - bus_wen      in   1      bus write strobe, one cycle per access
// - bus_ren      in   1      bus read strobe (no side effects on reads)
// - bus_wdata    in   32     bus write data
// - bus_rdata    out  32     register read data, combinational from bus_addr
// - frame_start  in   1      one-cycle pulse: first dot-enable of the frame (hpos==0 && vpos==0 && clk_en)
// - rd_en        in   1      display read enable
// - rd_idx       in   IDX_W  display pixel index
// - rd_data      out  PIX_W  front-bank pixel, registered, valid 1 cycle after rd_en
// BEHAVIOUR
// - Decode: selected when bus_addr[31:20]==BASE_SPRITE[31:20]; register = bus_addr[4:2]:
//   0 CTRL  (W) bit0 SWAP_REQ, bit1 AUTOINC enable (sticky), bit2 FILL_START
//   1 PTR   (RW) back-bank write index [IDX_W-1:0]
//   2 DATA  (W) write bus_wdata[PIX_W-1:0] to back[PTR]; if AUTOINC, PTR <= PTR+1 mod 2**IDX_W (16383 -> 0)
//   3 STATUS(R) bit0 swap_pending, bit1 front_sel, bit2 fill_busy, bit3 overrun (W1C on bit3), [31:16] swap_count
//   4 FILL  (RW) fill colour [PIX_W-1:0]
//   Unselected/unused reads: 32'h0; DATA/CTRL reads return 32'h0.
// - Reset: front_sel=0, PTR=0, AUTOINC=0, swap_pending=0, fill FSM IDLE, overrun=0, swap_count=0, FILL=0, rd_data=0.
//   Memory contents not cleared. rst mid-fill aborts fill immediately; partially filled bank kept.
// - Back bank = ~front_sel. Bus writes and fill writes target back bank only; display reads front bank only.
// - Swap FSM: swap_pending set by SWAP_REQ; on frame_start with pending && !fill_busy: front_sel toggles,
//   pending cleared, swap_count+1 (wraps at 16 bits), all in the cycle after frame_start.
//   SWAP_REQ and frame_start in same cycle -> swap on that frame_start. Repeated SWAP_REQ while pending: no effect.
//   Pending during fill -> deferred to first frame_start after fill completes.
// - Fill FSM: IDLE -> FILL on FILL_START (ignored if already FILL); writes FILL colour to back[0..2**IDX_W-1],
//   one pixel/cycle, fill counter from 0; returns to IDLE after index 2**IDX_W-1 (16384 cycles).
//   fill_busy=1 from cycle after FILL_START through last write cycle.
// - DATA write while fill_busy: dropped, PTR unchanged, overrun set (sticky until W1C).
// - CTRL with SWAP_REQ and FILL_START together: fill starts, swap deferred until fill done.
// - rd_data: registered read of front[rd_idx] when rd_en; holds value when !rd_en. Swap affects reads issued after front_sel toggles.
// STRUCTURE
// - reg_map_pkg: BASE_SPRITE = 32'hf810_0000, offset constants R_SPR_CTRL..R_SPR_FILL, CTRL/STATUS bit indices.
// - Sub-module sprite_bank_ram: simple dual-port RAM (1 write, 1 registered read), instantiated twice;
//   write mux (bus vs fill) and bank select in sprite_dbuf.
// - Top-level wiring: display path computes rd_idx; lcd_db pixel swizzle stays outside this block.
// TESTING
// - Reset, AUTOINC=1, PTR=0, DATA x3 (0x3ffff,0x00fc0,0x0003f) -> PTR=3; SWAP_REQ, frame_start -> front_sel=1, rd_idx 0..2 return those values 1 cycle later.
// - PTR=16383, AUTOINC, DATA 0x12345 -> PTR reads 0; after swap rd_idx 16383 = 0x12345.
// - FILL=0x2aaaa, FILL_START -> fill_busy for 16384 cycles; DATA write mid-fill -> overrun=1, PTR unchanged; after swap all sampled indices = 0x2aaaa.
// - SWAP_REQ coincident with frame_start -> swap_count 0->1 next cycle; second SWAP_REQ with no frame_start -> pending=1, front unchanged.
// - SWAP_REQ during fill, frame_start before fill end -> no swap; first frame_start after fill -> swap.
// - rst asserted mid-fill -> fill_busy=0, front_sel=0, PTR=0, pending=0 next cycle; unselected bus read -> 32'h0.

Source files
------------

// File: rtl/sprite_dbuf_pkg.sv
// sprite_dbuf_pkg
// Shared constants for the double-buffered sprite store: bus base address,
// register offsets (bus_addr[4:2]), CTRL/STATUS bit positions, default
// geometry and the fill engine state type.
package sprite_dbuf_pkg;

  localparam int IDX_W_DEF = 14;   // {row[6:0], col[6:0]}
  localparam int PIX_W_DEF = 18;   // RGB666 {r, g, b}

  localparam logic [31:0] BASE_SPRITE = 32'hf810_0000;

  localparam logic [2:0] R_SPR_CTRL   = 3'd0;
  localparam logic [2:0] R_SPR_PTR    = 3'd1;
  localparam logic [2:0] R_SPR_DATA   = 3'd2;
  localparam logic [2:0] R_SPR_STATUS = 3'd3;
  localparam logic [2:0] R_SPR_FILL   = 3'd4;

  localparam int CTRL_SWAP_REQ   = 0;
  localparam int CTRL_AUTOINC    = 1;
  localparam int CTRL_FILL_START = 2;

  localparam int ST_SWAP_PENDING = 0;
  localparam int ST_FRONT_SEL    = 1;
  localparam int ST_FILL_BUSY    = 2;
  localparam int ST_OVERRUN      = 3;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_t;

  // Block is selected by the top 12 address bits only.
  function automatic logic is_sprite_sel(input logic [31:0] addr);
    return addr[31:20] == BASE_SPRITE[31:20];
  endfunction

endpackage

// File: rtl/sprite_bank_ram.sv
// sprite_bank_ram
// One sprite bank: simple dual-port RAM with one write port and one
// registered read port. Contents are never reset so it maps onto block RAM.
// Ports:
//   clk_50mhz          system clock
//   wr_en/wr_idx/wr_data  write port
//   rd_en/rd_idx       read request; rd_data updates on the next edge and
//                      holds while rd_en is low
module sprite_bank_ram
  import sprite_dbuf_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk_50mhz,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem_reg [0:(1<<IDX_W)-1];
  logic [PIX_W-1:0] rd_data_reg;

  always_ff @(posedge clk_50mhz) begin
    if (wr_en) begin
      mem_reg[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_idx];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/sprite_dbuf.sv
// sprite_dbuf
// Double-buffered sprite store for the LCD pipeline. The MCU writes the back
// bank through a small register window; the display reads the front bank.
// Banks swap only on frame_start so the panel never shows a half-written
// image. A fill engine can paint the whole back bank with one colour.
// Ports:
//   clk_50mhz, rst      clock and synchronous active-high reset
//   bus_*               SPI-slave register bus; bus_rdata is combinational
//   frame_start         one-cycle pulse at the first dot of each frame
//   rd_en, rd_idx       display read request into the front bank
//   rd_data             front-bank pixel, one cycle after rd_en, held otherwise
module sprite_dbuf
  import sprite_dbuf_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic [31:0]      bus_addr,
  input  logic             bus_wen,
  input  logic             bus_ren,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  input  logic             frame_start,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [PIX_W-1:0] rd_data
);

  // Reads have no side effects and only part of the address/data is decoded.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus_ren, bus_addr[19:5], bus_addr[1:0], bus_wdata[31:PIX_W]};

  // ---------------- register decode ----------------
  logic       sel;
  logic [2:0] reg_off;
  logic       wr_ctrl, wr_ptr, wr_data, wr_status, wr_fill;
  logic       swap_req_now, fill_req_now, data_wr_ok, overrun_set, swap_go;

  // ---------------- state ----------------
  logic             front_sel_reg;
  logic             swap_pending_reg;
  logic [15:0]      swap_count_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;
  logic             autoinc_reg;
  logic             overrun_reg;
  logic [PIX_W-1:0] fill_colour_reg;
  fill_state_t      fill_state_reg;
  logic             fill_busy_reg;
  logic [IDX_W-1:0] fill_cnt_reg;
  logic             rd_valid_reg;
  logic             rd_sel_reg;

  assign sel       = is_sprite_sel(bus_addr);
  assign reg_off   = bus_addr[4:2];
  assign wr_ctrl   = bus_wen && sel && (reg_off == R_SPR_CTRL);
  assign wr_ptr    = bus_wen && sel && (reg_off == R_SPR_PTR);
  assign wr_data   = bus_wen && sel && (reg_off == R_SPR_DATA);
  assign wr_status = bus_wen && sel && (reg_off == R_SPR_STATUS);
  assign wr_fill   = bus_wen && sel && (reg_off == R_SPR_FILL);

  assign swap_req_now = wr_ctrl && bus_wdata[CTRL_SWAP_REQ];
  assign fill_req_now = wr_ctrl && bus_wdata[CTRL_FILL_START];

  // The bus loses to the fill engine: a DATA write during a fill is dropped.
  assign data_wr_ok  = wr_data && !fill_busy_reg;
  assign overrun_set = wr_data && fill_busy_reg;

  // A fill request in the same cycle counts as busy, so a combined
  // SWAP_REQ+FILL_START (or a fill started on a frame_start) defers the swap.
  assign swap_go = frame_start && (swap_pending_reg || swap_req_now)
                   && !fill_busy_reg && !fill_req_now;

  always_comb begin
    ptr_next = ptr_reg;
    if (wr_ptr) begin
      ptr_next = bus_wdata[IDX_W-1:0];
    end else if (data_wr_ok && autoinc_reg) begin
      ptr_next = ptr_reg + IDX_W'(1);
    end
  end

  // ---------------- swap / register state ----------------
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      front_sel_reg    <= 1'b0;
      swap_pending_reg <= 1'b0;
      swap_count_reg   <= 16'd0;
      ptr_reg          <= '0;
      autoinc_reg      <= 1'b0;
      overrun_reg      <= 1'b0;
      fill_colour_reg  <= '0;
    end else begin
      if (swap_go) begin
        front_sel_reg    <= ~front_sel_reg;
        swap_pending_reg <= 1'b0;
        swap_count_reg   <= swap_count_reg + 16'd1;
      end else if (swap_req_now) begin
        swap_pending_reg <= 1'b1;
      end

      ptr_reg <= ptr_next;

      if (wr_ctrl) begin
        autoinc_reg <= bus_wdata[CTRL_AUTOINC];
      end

      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (wr_status && bus_wdata[ST_OVERRUN]) begin
        overrun_reg <= 1'b0;
      end

      if (wr_fill) begin
        fill_colour_reg <= bus_wdata[PIX_W-1:0];
      end
    end
  end

  // ---------------- fill engine ----------------
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      fill_state_reg <= FILL_IDLE;
      fill_busy_reg  <= 1'b0;
      fill_cnt_reg   <= '0;
    end else begin
      case (fill_state_reg)
        FILL_IDLE: begin
          if (fill_req_now) begin
            fill_state_reg <= FILL_RUN;
            fill_busy_reg  <= 1'b1;
            fill_cnt_reg   <= '0;
          end
        end
        FILL_RUN: begin
          fill_cnt_reg <= fill_cnt_reg + IDX_W'(1);
          if (&fill_cnt_reg) begin
            fill_state_reg <= FILL_IDLE;
            fill_busy_reg  <= 1'b0;
          end
        end
        default: begin
          fill_state_reg <= FILL_IDLE;
          fill_busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- write mux and banks ----------------
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [PIX_W-1:0] wr_pix;
  logic             back_sel;
  logic [PIX_W-1:0] bank_q [2];

  assign back_sel = ~front_sel_reg;
  assign wr_en    = fill_busy_reg || data_wr_ok;
  assign wr_idx   = fill_busy_reg ? fill_cnt_reg : ptr_reg;
  assign wr_pix   = fill_busy_reg ? fill_colour_reg : bus_wdata[PIX_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic bank_we;
      assign bank_we = wr_en && (back_sel == 1'(gi));

      // Both banks are read; the bank that was front at request time is
      // picked on the output so a swap never changes an in-flight read.
      sprite_bank_ram #(
        .IDX_W(IDX_W),
        .PIX_W(PIX_W)
      ) u_ram (
        .clk_50mhz(clk_50mhz),
        .wr_en    (bank_we),
        .wr_idx   (wr_idx),
        .wr_data  (wr_pix),
        .rd_en    (rd_en),
        .rd_idx   (rd_idx),
        .rd_data  (bank_q[gi])
      );
    end
  endgenerate

  // RAM output registers have no reset; rd_valid_reg forces rd_data to zero
  // until the first read after reset.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rd_sel_reg   <= 1'b0;
    end else if (rd_en) begin
      rd_valid_reg <= 1'b1;
      rd_sel_reg   <= front_sel_reg;
    end
  end

  assign rd_data = rd_valid_reg ? bank_q[rd_sel_reg] : '0;

  // ---------------- register read ----------------
  always_comb begin
    bus_rdata = 32'h0;
    if (sel) begin
      case (reg_off)
        R_SPR_PTR:    bus_rdata = 32'(ptr_reg);
        R_SPR_STATUS: bus_rdata = {swap_count_reg, 12'h000, overrun_reg,
                                   fill_busy_reg, front_sel_reg, swap_pending_reg};
        R_SPR_FILL:   bus_rdata = 32'(fill_colour_reg);
        default:      bus_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_dbuf.sv
// tb_sprite_dbuf
// Directed stimulus with a scoreboard: every bus read or pixel read pushes
// its hand-computed expected value; a monitor on the falling clock edge pops
// and compares whenever the DUT presents a bus read or a pixel.
module tb_sprite_dbuf;

  localparam int IDX_W = 14;
  localparam int PIX_W = 18;

  localparam logic [31:0] A_CTRL   = 32'hf810_0000;
  localparam logic [31:0] A_PTR    = 32'hf810_0004;
  localparam logic [31:0] A_DATA   = 32'hf810_0008;
  localparam logic [31:0] A_STATUS = 32'hf810_000c;
  localparam logic [31:0] A_FILL   = 32'hf810_0010;
  localparam logic [31:0] A_OTHER  = 32'hf820_000c;

  logic             clk_50mhz = 1'b0;
  logic             rst;
  logic [31:0]      bus_addr;
  logic             bus_wen;
  logic             bus_ren;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_rdata;
  logic             frame_start;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [PIX_W-1:0] rd_data;

  always #5 clk_50mhz = ~clk_50mhz;

  sprite_dbuf #(
    .IDX_W(IDX_W),
    .PIX_W(PIX_W)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_wen    (bus_wen),
    .bus_ren    (bus_ren),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .frame_start(frame_start),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t bus_q[$];
  exp_t pix_q[$];

  int checks = 0;
  int errors = 0;

  logic pix_due  = 1'b0;
  logic pix_hold = 1'b0;

  // Expected STATUS fields, updated by hand next to the stimulus.
  logic [15:0] m_count;
  logic        m_front, m_pend, m_ovr;

  function automatic logic [31:0] st(input logic busy);
    return {m_count, 12'h000, m_ovr, busy, m_front, m_pend};
  endfunction

  // ---------------- monitor ----------------
  task automatic compare(input string what, input string name, input logic [31:0] got,
                         input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", what, name, got, exp);
    end else begin
      $display("ok   %s %s: got %h", what, name, got);
    end
  endtask

  task automatic pop_pix();
    exp_t e;
    if (pix_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL pix unexpected: got %h expected nothing", rd_data);
    end else begin
      e = pix_q.pop_front();
      compare("pix", e.name, 32'(rd_data), e.val);
    end
  endtask

  always @(posedge clk_50mhz) pix_due <= rd_en;

  always @(negedge clk_50mhz) begin
    exp_t e;
    if (bus_ren) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus unexpected: got %h expected nothing", bus_rdata);
      end else begin
        e = bus_q.pop_front();
        compare("bus", e.name, bus_rdata, e.val);
      end
    end
    if (pix_due)  pop_pix();
    if (pix_hold) pop_pix();
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
    tick();
    bus_wen = 1'b0;
  endtask

  task automatic wr_fs(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1; frame_start = 1'b1;
    tick();
    bus_wen = 1'b0; frame_start = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name; e.val = exp;
    bus_q.push_back(e);
    bus_addr = a; bus_ren = 1'b1;
    tick();
    bus_ren = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic px(input logic [IDX_W-1:0] idx, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name; e.val = exp;
    pix_q.push_back(e);
    rd_idx = idx; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic px_hold(input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name; e.val = exp;
    pix_q.push_back(e);
    pix_hold = 1'b1;
    tick();
    pix_hold = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [IDX_W-1:0] fill_idx [5];

  initial begin
    rst = 1'b1; bus_addr = '0; bus_wen = 1'b0; bus_ren = 1'b0; bus_wdata = '0;
    frame_start = 1'b0; rd_en = 1'b0; rd_idx = '0;
    m_count = 16'd0; m_front = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
    repeat (3) @(posedge clk_50mhz);
    #1;
    rst = 1'b0;

    // Reset state and zero-reading registers
    rd(A_STATUS, st(1'b0), "rst_status");
    rd(A_PTR, 32'h0, "rst_ptr");
    rd(A_FILL, 32'h0, "rst_fill");
    px_hold(32'h0, "rst_rd_data");
    rd(A_CTRL, 32'h0, "ctrl_reads_zero");
    wr(A_DATA, 32'h15555);
    rd(A_PTR, 32'h0, "no_autoinc_ptr");

    // Load three pixels with auto-increment, then swap on frame_start
    wr(A_CTRL, 32'h2);
    wr(A_PTR, 32'h0);
    wr(A_DATA, 32'h3ffff);
    wr(A_DATA, 32'h00fc0);
    wr(A_DATA, 32'h0003f);
    rd(A_PTR, 32'h3, "autoinc_ptr");
    rd(A_DATA, 32'h0, "data_reads_zero");
    wr(A_CTRL, 32'h3);
    m_pend = 1'b1;
    rd(A_STATUS, st(1'b0), "swap_pending");
    fs();
    m_front = 1'b1; m_pend = 1'b0; m_count = 16'd1;
    rd(A_STATUS, st(1'b0), "swap_done");
    px(14'd0, 32'h3ffff, "pix0");
    px(14'd1, 32'h00fc0, "pix1");
    px(14'd2, 32'h0003f, "pix2");
    tick();
    tick();
    px_hold(32'h0003f, "rd_hold");

    // PTR wrap, and SWAP_REQ coincident with frame_start
    wr(A_PTR, 32'h3fff);
    wr(A_CTRL, 32'h2);
    wr(A_DATA, 32'h12345);
    rd(A_PTR, 32'h0, "ptr_wrap");
    wr_fs(A_CTRL, 32'h3);
    m_front = 1'b0; m_count = 16'd2;
    rd(A_STATUS, st(1'b0), "swap_coincident");
    px(14'd16383, 32'h12345, "pix_last");

    // Request without frame_start, repeated request, one swap only
    wr(A_CTRL, 32'h1);
    m_pend = 1'b1;
    rd(A_STATUS, st(1'b0), "pend_no_fs");
    wr(A_CTRL, 32'h1);
    rd(A_STATUS, st(1'b0), "pend_repeat");
    fs();
    m_front = 1'b1; m_pend = 1'b0; m_count = 16'd3;
    rd(A_STATUS, st(1'b0), "swap_once");
    fs();
    rd(A_STATUS, st(1'b0), "no_req_no_swap");

    // Fill of the back bank; cycle k counts from the first fill write
    wr(A_FILL, 32'h2aaaa);
    rd(A_FILL, 32'h2aaaa, "fill_reg");
    wr(A_PTR, 32'd100);
    wr(A_CTRL, 32'h4);                         // now k=0
    rd(A_STATUS, st(1'b1), "fill_busy_start"); // k=1
    wr(A_DATA, 32'h11111);                     // k=2
    m_ovr = 1'b1;
    rd(A_PTR, 32'd100, "ptr_overrun");         // k=3
    rd(A_STATUS, st(1'b1), "overrun_set");     // k=4
    wr(A_CTRL, 32'h1);                         // k=5
    m_pend = 1'b1;
    fs();                                      // k=6
    rd(A_STATUS, st(1'b1), "no_swap_in_fill"); // k=7
    repeat (16376) tick();                     // k=16383
    rd(A_STATUS, st(1'b1), "fill_last_busy");
    rd(A_STATUS, st(1'b0), "fill_done");
    wr(A_STATUS, 32'h8);
    m_ovr = 1'b0;
    rd(A_STATUS, st(1'b0), "overrun_w1c");
    fs();
    m_front = 1'b0; m_pend = 1'b0; m_count = 16'd4;
    rd(A_STATUS, st(1'b0), "swap_after_fill");
    fill_idx[0] = 14'd0;
    fill_idx[1] = 14'd1;
    fill_idx[2] = 14'd100;
    fill_idx[3] = 14'd8191;
    fill_idx[4] = 14'd16383;
    for (int i = 0; i < 5; i++) begin
      px(fill_idx[i], 32'h2aaaa, $sformatf("fill_pix_%0d", fill_idx[i]));
    end

    // SWAP_REQ+FILL_START together, then reset in the middle of the fill
    wr(A_PTR, 32'd55);
    wr(A_CTRL, 32'h7);
    m_pend = 1'b1;
    fs();
    rd(A_STATUS, st(1'b1), "combo_deferred");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_count = 16'd0; m_front = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
    rd(A_STATUS, st(1'b0), "rst_mid_fill");
    rd(A_PTR, 32'h0, "rst_ptr_mid_fill");
    rd(A_OTHER, 32'h0, "unselected");
    px_hold(32'h0, "rst_rd_data_mid_fill");

    tick();
    tick();
    if (bus_q.size() != 0 || pix_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d bus and %0d pix pending expected 0", bus_q.size(), pix_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
